// File: rtl/adder_pkg.sv
// Shared constants and types for the memory-mapped adder peripheral.
package adder_pkg;

  localparam logic [1:0] IDX_OPA    = 2'd0;
  localparam logic [1:0] IDX_OPB    = 2'd1;
  localparam logic [1:0] IDX_SUM    = 2'd2;
  localparam logic [1:0] IDX_STATUS = 2'd3;

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_ACCEPT = 2'd1,
    W_RESP   = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_ACCEPT = 2'd1,
    R_DATA   = 2'd2
  } rd_state_e;

  // Only the two operand registers accept writes; SUM and STATUS are derived.
  function automatic logic idx_writable(input logic [1:0] idx);
    return (idx == IDX_OPA) || (idx == IDX_OPB);
  endfunction

endpackage

// File: rtl/adder_regfile.sv
// Operand storage with byte-strobe writes, the sum/carry datapath and the read mux.
module adder_regfile
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [1:0]              wr_idx_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_strb_i,
  input  logic [1:0]              rd_idx_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o
);

  logic [DATA_WIDTH-1:0] opa_q, opa_d;
  logic [DATA_WIDTH-1:0] opb_q, opb_d;
  logic [DATA_WIDTH:0]   sum_full;

  always_comb begin
    opa_d = opa_q;
    opb_d = opb_q;
    if (wr_en_i) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (wr_strb_i[b]) begin
          if (wr_idx_i == IDX_OPA) opa_d[b*8 +: 8] = wr_data_i[b*8 +: 8];
          if (wr_idx_i == IDX_OPB) opb_d[b*8 +: 8] = wr_data_i[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      opa_q <= '0;
      opb_q <= '0;
    end else begin
      opa_q <= opa_d;
      opb_q <= opb_d;
    end
  end

  // One extra bit holds the carry-out reported through STATUS.
  assign sum_full = {1'b0, opa_q} + {1'b0, opb_q};

  always_comb begin
    rd_data_o = '0;
    case (rd_idx_i)
      IDX_OPA:    rd_data_o = opa_q;
      IDX_OPB:    rd_data_o = opb_q;
      IDX_SUM:    rd_data_o = sum_full[DATA_WIDTH-1:0];
      IDX_STATUS: rd_data_o = {{(DATA_WIDTH-1){1'b0}}, sum_full[DATA_WIDTH]};
      default:    rd_data_o = '0;
    endcase
  end

endmodule

// File: rtl/adder.sv
// AXI4-Lite-style slave front end: independent write and read handshake FSMs around adder_regfile.
module adder
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    s1_axi_aclk,
  input  logic                    s1_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic                    s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic                    s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready,
  output logic [1:0]              dbg_wr_state_o,
  output logic [1:0]              dbg_rd_state_o
);

  // Handshake rule: a transfer completes on the rising edge where both valid
  // and ready are high; valid must then be held by its source until that edge.

  // The reset input is active-high despite its name.
  logic rst;
  assign rst = s1_axi_aresetn;

  wr_state_e             wr_state_q, wr_state_d;
  rd_state_e             rd_state_q, rd_state_d;
  logic                  bresp_q, bresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  wr_fire;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  unused_addr_bits;

  // Only addr[1:0] decodes; upper bits alias.
  assign unused_addr_bits = ^{s1_axi_awaddr[ADDR_WIDTH-1:2], s1_axi_araddr[ADDR_WIDTH-1:2]};

  always_comb begin
    wr_state_d = wr_state_q;
    bresp_d    = bresp_q;
    wr_fire    = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (s1_axi_awvalid && s1_axi_wvalid) wr_state_d = W_ACCEPT;
      end
      W_ACCEPT: begin
        if (s1_axi_awvalid && s1_axi_wvalid) begin
          wr_fire    = 1'b1;
          bresp_d    = idx_writable(s1_axi_awaddr[1:0]) ? RESP_OKAY : RESP_SLVERR;
          wr_state_d = W_RESP;
        end else begin
          wr_state_d = W_IDLE;
        end
      end
      W_RESP: begin
        if (s1_axi_bready) begin
          bresp_d    = RESP_OKAY;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      R_IDLE: begin
        if (s1_axi_arvalid) rd_state_d = R_ACCEPT;
      end
      R_ACCEPT: begin
        if (s1_axi_arvalid) begin
          rdata_d    = rd_data;
          rd_state_d = R_DATA;
        end else begin
          rd_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (s1_axi_rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s1_axi_aclk or posedge rst) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      bresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      bresp_q    <= bresp_d;
      rdata_q    <= rdata_d;
    end
  end

  assign wr_en = wr_fire && idx_writable(s1_axi_awaddr[1:0]);

  // Read capture and register write share an edge, so a same-register read sees the old value.
  adder_regfile #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_regfile (
    .clk_i     (s1_axi_aclk),
    .rst_i     (rst),
    .wr_en_i   (wr_en),
    .wr_idx_i  (s1_axi_awaddr[1:0]),
    .wr_data_i (s1_axi_wdata),
    .wr_strb_i (s1_axi_wstrb),
    .rd_idx_i  (s1_axi_araddr[1:0]),
    .rd_data_o (rd_data)
  );

  assign s1_axi_awready = (wr_state_q == W_ACCEPT);
  assign s1_axi_wready  = (wr_state_q == W_ACCEPT);
  assign s1_axi_bvalid  = (wr_state_q == W_RESP);
  assign s1_axi_bresp   = bresp_q;
  assign s1_axi_arready = (rd_state_q == R_ACCEPT);
  assign s1_axi_rvalid  = (rd_state_q == R_DATA);
  assign s1_axi_rdata   = rdata_q;
  assign s1_axi_rresp   = RESP_OKAY;
  assign dbg_wr_state_o = wr_state_q;
  assign dbg_rd_state_o = rd_state_q;

endmodule

// File: tb/tb_adder.sv
// Directed bench for the adder peripheral: register map, strobes, aliasing, backpressure and streaming.
module tb_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic        bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [7:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic        rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [1:0]  dbg_wr_state;
  logic [1:0]  dbg_rd_state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .s1_axi_aclk    (clk),
    .s1_axi_aresetn (rst),
    .s1_axi_awaddr  (awaddr),
    .s1_axi_awvalid (awvalid),
    .s1_axi_awready (awready),
    .s1_axi_wdata   (wdata),
    .s1_axi_wstrb   (wstrb),
    .s1_axi_wvalid  (wvalid),
    .s1_axi_wready  (wready),
    .s1_axi_bresp   (bresp),
    .s1_axi_bvalid  (bvalid),
    .s1_axi_bready  (bready),
    .s1_axi_araddr  (araddr),
    .s1_axi_arvalid (arvalid),
    .s1_axi_arready (arready),
    .s1_axi_rdata   (rdata),
    .s1_axi_rresp   (rresp),
    .s1_axi_rvalid  (rvalid),
    .s1_axi_rready  (rready),
    .dbg_wr_state_o (dbg_wr_state),
    .dbg_rd_state_o (dbg_rd_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic resp);
    logic got;
    got = 1'b0;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (awready) begin got = 1'b1; break; end
    end
    chk("wr_accept", {31'b0, got & wready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_bvalid", {31'b0, bvalid}, 32'd1);
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data);
    logic got;
    got = 1'b0;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (arready) begin got = 1'b1; break; end
    end
    chk("rd_accept", {31'b0, got}, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rd_rvalid", {31'b0, rvalid}, 32'd1);
    chk("rd_rresp", {31'b0, rresp}, 32'd0);
    data = rdata;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  function automatic logic [31:0] reg_model(input logic [1:0] idx, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (idx)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return s[31:0];
      default: return {31'b0, s[32]};
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r;
    logic [31:0] d;
    logic [31:0] m_a, m_b, rd_exp;
    logic        aw_prev, ar_prev, got;
    int          wk, rk, last_aw;

    // Reset held two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", {31'b0, awready}, 0);
    chk("rst_wready",  {31'b0, wready}, 0);
    chk("rst_bvalid",  {31'b0, bvalid}, 0);
    chk("rst_bresp",   {31'b0, bresp}, 0);
    chk("rst_arready", {31'b0, arready}, 0);
    chk("rst_rvalid",  {31'b0, rvalid}, 0);
    chk("rst_rdata",   rdata, 0);
    chk("rst_rresp",   {31'b0, rresp}, 0);
    chk("rst_dbg",     {28'b0, dbg_wr_state, dbg_rd_state}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    axi_read(8'd2, d);  chk("rst_sum", d, 0);

    // Basic sum
    axi_write(8'd0, 32'd23, 4'hF, r); chk("w23_bresp", {31'b0, r}, 0);
    axi_write(8'd1, 32'd30, 4'hF, r); chk("w30_bresp", {31'b0, r}, 0);
    axi_read(8'd2, d);  chk("sum_53", d, 32'd53);
    axi_read(8'd3, d);  chk("status_0", d, 32'd0);

    // Carry out
    axi_write(8'd0, 32'hFFFF_FFFF, 4'hF, r);
    axi_write(8'd1, 32'd2, 4'hF, r);
    axi_read(8'd2, d);  chk("sum_wrap", d, 32'd1);
    axi_read(8'd3, d);  chk("status_carry", d, 32'd1);

    // Aliasing, read-only write, strobes
    axi_write(8'd4, 32'd37, 4'hF, r); chk("alias_bresp", {31'b0, r}, 0);
    axi_read(8'd0, d);  chk("alias_opa", d, 32'd37);
    axi_read(8'h84, d); chk("alias_rd", d, 32'd37);
    axi_write(8'd2, 32'd5, 4'hF, r);  chk("ro_bresp", {31'b0, r}, 1);
    axi_read(8'd2, d);  chk("ro_sum", d, 32'd39);
    axi_write(8'd0, 32'd0, 4'hF, r);
    axi_write(8'd0, 32'hAABB_CCDD, 4'h1, r);
    axi_read(8'd0, d);  chk("strb_lane0", d, 32'h0000_00DD);
    axi_write(8'd1, 32'hFFFF_FFFF, 4'h0, r); chk("strb0_bresp", {31'b0, r}, 0);
    axi_read(8'd1, d);  chk("strb0_opb", d, 32'd2);

    // Write-response backpressure
    awaddr = 8'd1; wdata = 32'h11; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (awready) begin got = 1'b1; break; end
    end
    chk("bp_accept1", {31'b0, got}, 1);
    @(posedge clk); #1;
    awaddr = 8'd0; wdata = 32'h77;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("bp_bvalid_hold", {31'b0, bvalid}, 1);
      chk("bp_awready_low", {31'b0, awready}, 0);
    end
    bready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (awready) begin got = 1'b1; break; end
    end
    chk("bp_accept2", {31'b0, got}, 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bp_bvalid2", {31'b0, bvalid}, 1);
    @(posedge clk); #1;
    bready = 1'b0;
    axi_read(8'd0, d);  chk("bp_opa", d, 32'h77);
    axi_read(8'd1, d);  chk("bp_opb", d, 32'h11);

    // Read-data backpressure, with a write landing while rdata is held
    araddr = 8'd2; arvalid = 1'b1; rready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (arready) begin got = 1'b1; break; end
    end
    chk("rbp_accept", {31'b0, got}, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rbp_rvalid", {31'b0, rvalid}, 1);
    chk("rbp_rdata", rdata, 32'h88);
    axi_write(8'd0, 32'd1, 4'hF, r);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rbp_rvalid_hold", {31'b0, rvalid}, 1);
      chk("rbp_rdata_hold", rdata, 32'h88);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    chk("rbp_release", {31'b0, rvalid}, 0);
    rready = 1'b0;
    axi_read(8'd2, d);  chk("rbp_newsum", d, 32'h12);

    // Streaming: valids held, addresses advance after each handshake
    m_a = 32'd1; m_b = 32'h11;
    wk = 0; rk = 0; last_aw = -1;
    aw_prev = 1'b0; ar_prev = 1'b0; rd_exp = '0;
    awaddr = 8'd0; wdata = 32'h8000_0003; wstrb = 4'hF;
    araddr = 8'd0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      if (ar_prev) rd_exp = reg_model(araddr[1:0], m_a, m_b);
      if (aw_prev) begin
        if (awaddr[1:0] == 2'd0) m_a = wdata;
        if (awaddr[1:0] == 2'd1) m_b = wdata;
      end
      #1;
      if (ar_prev) begin
        chk("st_rvalid", {31'b0, rvalid}, 1);
        chk("st_rdata", rdata, rd_exp);
        rk++;
        araddr = 8'(rk);
      end
      if (aw_prev) begin
        chk("st_bvalid", {31'b0, bvalid}, 1);
        chk("st_bresp", {31'b0, bresp}, {31'b0, awaddr[1]});
        wk++;
        awaddr = 8'(wk);
        wdata = 32'h8000_0003 + 32'(wk) * 32'h0101_0101;
      end
      if (awready) begin
        if (last_aw >= 0) chk("st_wr_period", 32'(c - last_aw), 32'd3);
        last_aw = c;
      end
      aw_prev = awready;
      ar_prev = arready;
    end
    chk("st_writes_done", {31'b0, (wk >= 8)}, 1);
    chk("st_reads_done", {31'b0, (rk >= 8)}, 1);

    // Reset with both channels busy
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {28'b0, awready, wready, arready, 1'b0}, 0);
    chk("mid_rst_valid", {30'b0, bvalid, rvalid}, 0);
    chk("mid_rst_rdata", rdata, 0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", {28'b0, dbg_wr_state, dbg_rd_state}, 0);
    axi_read(8'd0, d);  chk("post_rst_opa", d, 0);
    axi_read(8'd1, d);  chk("post_rst_opb", d, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
